// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard.
// Drives the open-drain PS2_CLK/PS2_DAT pads through output enables and exposes
// a status register on the peripheral bus.
// Optional build macro: PS2_TX_TIMEOUT_EN adds a watchdog that aborts a frame
// the device never finishes clocking.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        rw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic        ps2_clk_oe,
   output logic        ps2_dat_oe,
   output logic        tx_active
);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StShift,
      StAck,
      StWaitIdle
   } state_e;

   // One counter times the inhibit hold and, when enabled, the watchdog; the two
   // never run at the same time, so it is sized for the longer of them.
   localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
   localparam logic [CntW-1:0] ToLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [3:0]      idx_q;
   logic [7:0]      byte_q;
   logic            busy_q;
   logic            ack_ok_q;
   logic            error_q;
   logic            clk_oe_q;
   logic            dat_oe_q;
   logic [31:0]     rdata_q;

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic dat_meta_q, dat_sync_q;

   logic       fall;
   logic       start_wr;
   logic [9:0] frame;
   logic       unused_bits;

   assign fall     = clk_prev_q & ~clk_sync_q;
   assign start_wr = ena && rw && (addr[2:0] == 3'd0);
   // Bit 9 is the stop bit, bit 8 odd parity, bits 7:0 data sent LSB first.
   assign frame    = {1'b1, ~^byte_q, byte_q};

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign tx_active  = (state_q != StIdle);
   assign rdata      = rdata_q;

   assign unused_bits = ^{addr[31:3], wdata[31:8]};

   // Two-flop synchronizers for both pads plus a history flop for clock edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk_in;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_in;
         dat_sync_q <= dat_meta_q;
      end
   end

   // Frame sequencer with registered pad enables and status bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= 4'd0;
         byte_q   <= 8'h00;
         busy_q   <= 1'b0;
         ack_ok_q <= 1'b0;
         error_q  <= 1'b0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_wr) begin
                  byte_q   <= wdata[7:0];
                  ack_ok_q <= 1'b0;
                  error_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  clk_oe_q <= 1'b1;
                  dat_oe_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= StInhibit;
               end
            end
            StInhibit: begin
               // Release the clock and pull data low (start bit) together.
               if (cnt_q == InhLast) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= StReq;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StReq: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b1;
               idx_q    <= 4'd0;
               state_q  <= StShift;
            end
            StShift: begin
               if (fall) begin
                  dat_oe_q <= ~frame[idx_q];
                  if (idx_q == 4'd9) begin
                     state_q <= StAck;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            StAck: begin
               if (fall) begin
                  if (dat_sync_q) begin
                     error_q <= 1'b1;
                  end else begin
                     ack_ok_q <= 1'b1;
                  end
                  state_q <= StWaitIdle;
               end
            end
            StWaitIdle: begin
               if (clk_sync_q && dat_sync_q) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         // Watchdog overrides whatever the sequencer did this cycle.
         if (state_q inside {StReq, StShift, StAck, StWaitIdle}) begin
            if (cnt_q == ToLast) begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               error_q  <= 1'b1;
               ack_ok_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= StIdle;
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end
`endif
      end
   end

   // Status register read; the bus sees zero on every non-read cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'h0;
      end else if (ena && !rw) begin
         rdata_q <= {16'h0, byte_q, 5'b0, error_q, ack_ok_q, busy_q};
      end else begin
         rdata_q <= 32'h0;
      end
   end

endmodule
